// File: rtl/weight_fifo_sched.sv
// Weight FIFO bank sequencer: round-robin LOAD of a serial weight stream into
// N lanes, then a skewed DRAIN so weights enter the PE array diagonally.
module weight_fifo_sched #(
  parameter int N    = 16,
  parameter int W    = 8,
  parameter int ROWS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         drain_start,
  input  logic         drain_en,
  input  logic [N-1:0] empty,
  input  logic [N-1:0] full,
  output logic [N-1:0] wr,
  output logic [N-1:0] rd,
  output logic [W-1:0] data_out,
  output logic         loaded,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(ROWS + N);

  typedef enum logic [1:0] {IDLE, LOAD, LOADED, DRAIN} state_t;

  state_t        state;
  logic [LW-1:0] lane;
  logic [RW-1:0] row;
  logic [CW-1:0] c;
  logic          accept;
  logic          underflow;
  logic [N-1:0]  sched;

  always_comb begin
    in_ready = (state == LOAD) && !full[lane];
    accept   = in_valid && in_ready;
    wr       = accept ? (N'(1) << lane) : '0;
    data_out = (state == LOAD) ? in_data : '0;
    // Lane i is scheduled for the ROWS enabled cycles starting at c == i.
    for (int i = 0; i < N; i++) begin
      sched[i] = (int'(c) >= i) && (int'(c) < i + ROWS);
    end
    rd        = (state == DRAIN && drain_en) ? (sched & ~empty) : '0;
    underflow = (state == DRAIN) && drain_en && |(sched & empty);
  end

  assign loaded = (state == LOADED);
  assign busy   = (state == LOAD) || (state == DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lane  <= '0;
      row   <= '0;
      c     <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_start) err <= 1'b1;
          if (load_start) begin
            state <= LOAD;
            lane  <= '0;
            row   <= '0;
          end
        end
        LOAD: begin
          if (drain_start) err <= 1'b1;
          if (accept) begin
            if (lane == LW'(N - 1)) begin
              lane <= '0;
              if (row == RW'(ROWS - 1)) begin
                row   <= '0;
                state <= LOADED;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        LOADED: begin
          if (load_start) err <= 1'b1;
          if (drain_start) begin
            state <= DRAIN;
            c     <= '0;
          end
        end
        DRAIN: begin
          if (load_start || underflow) err <= 1'b1;
          // A suppressed underflow read still consumes its schedule slot.
          if (drain_en) begin
            if (c == CW'(ROWS + N - 2)) begin
              c     <= '0;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fifo_sched.sv
// Self-checking bench for weight_fifo_sched: scoreboarded LOAD writes and
// DRAIN read schedules, stalls, underflow, protocol errors and reset.
module tb_weight_fifo_sched;
  localparam int N    = 16;
  localparam int W    = 8;
  localparam int ROWS = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         drain_start;
  logic         drain_en;
  logic [N-1:0] empty;
  logic [N-1:0] full;
  logic [N-1:0] wr;
  logic [N-1:0] rd;
  logic [W-1:0] data_out;
  logic         loaded;
  logic         busy;
  logic         done;
  logic         err;

  int vectors     = 0;
  int miscompares = 0;

  logic [N+W-1:0] wq[$];
  logic [N-1:0]   rq[$];

  weight_fifo_sched #(.N(N), .W(W), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .drain_start(drain_start),
    .drain_en(drain_en), .empty(empty), .full(full), .wr(wr), .rd(rd),
    .data_out(data_out), .loaded(loaded), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    drain_start = 1'b0; drain_en = 1'b0; empty = '0; full = '0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({in_ready, wr, rd, data_out, loaded, busy, done, err} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: got %h required 0", k,
                 {in_ready, wr, rd, data_out, loaded, busy, done, err});
      end
      tick();
    end
  endtask

  task automatic test_load(input int stall_cycles);
    logic [N+W-1:0] exp;
    logic [W-1:0]   lane5[$];
    logic [W-1:0]   want5;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < N * ROWS; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k);
      wq.push_back({N'(1) << (k % N), W'(k)});
      if (k == 3 && stall_cycles > 0) begin
        full[3] = 1'b1;
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clk);
          vectors++;
          if (in_ready !== 1'b0 || wr !== '0) begin
            miscompares++;
            $display("[TB] FAIL load_stall cycle %0d: in_ready=%b wr=%h required 0/0", s, in_ready, wr);
          end
          tick();
        end
        full = '0;
      end
      @(negedge clk);
      exp = wq.pop_front();
      vectors++;
      if ({in_ready, wr, data_out} !== {1'b1, exp}) begin
        miscompares++;
        $display("[TB] FAIL load_write k=%0d: got rdy=%b wr=%h d=%h required rdy=1 wr=%h d=%h",
                 k, in_ready, wr, data_out, exp[N+W-1:W], exp[W-1:0]);
      end
      if (wr[5]) lane5.push_back(data_out);
      tick();
    end
    in_data = 8'hAA;
    @(negedge clk);
    vectors++;
    if ({loaded, busy, in_ready, wr} !== {1'b1, 1'b0, 1'b0, {N{1'b0}}}) begin
      miscompares++;
      $display("[TB] FAIL load_end: loaded=%b busy=%b in_ready=%b wr=%h required 1/0/0/0",
               loaded, busy, in_ready, wr);
    end
    in_valid = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      want5 = W'(5 + r * N);
      vectors++;
      if (lane5.size() <= r) begin
        miscompares++;
        $display("[TB] FAIL lane5_data row %0d: missing, required %0d", r, want5);
      end else if (lane5[r] !== want5) begin
        miscompares++;
        $display("[TB] FAIL lane5_data row %0d: got %0d required %0d", r, lane5[r], want5);
      end
    end
  endtask

  task automatic test_drain(input int sa, input int sb, input int el, input int ec,
                            input logic exp_err);
    int mc = 0;
    int t  = 0;
    int cnt[N];
    int want;
    logic [N-1:0] exp;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drain_start = 1'b1;
    drain_en    = 1'b1;
    tick();
    drain_start = 1'b0;
    while (mc < ROWS + N - 1) begin
      if (t > 200) begin
        miscompares++;
        $display("[TB] FAIL drain_timeout: mc=%0d after %0d cycles", mc, t);
        break;
      end
      drain_en = (t != sa) && (t != sb);
      empty = '0;
      if (el >= 0 && mc == ec) empty[el] = 1'b1;
      exp = '0;
      for (int i = 0; i < N; i++)
        if (drain_en && mc >= i && mc < i + ROWS && !empty[i]) exp[i] = 1'b1;
      rq.push_back(exp);
      @(negedge clk);
      exp = rq.pop_front();
      vectors++;
      if (rd !== exp || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL drain_rd t=%0d: rd=%h busy=%b done=%b required rd=%h busy=1 done=0",
                 t, rd, busy, done, exp);
      end
      for (int i = 0; i < N; i++) if (rd[i]) cnt[i]++;
      tick();
      if (drain_en) mc++;
      t++;
    end
    drain_en = 1'b0;
    empty = '0;
    @(negedge clk);
    vectors++;
    if ({done, busy, loaded, rd} !== {1'b1, 1'b0, 1'b0, {N{1'b0}}}) begin
      miscompares++;
      $display("[TB] FAIL drain_done: done=%b busy=%b loaded=%b rd=%h required 1/0/0/0",
               done, busy, loaded, rd);
    end
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL drain_err: got %b required %b", err, exp_err);
    end
    want = ROWS + N - 1 + ((sa >= 0) ? 1 : 0) + ((sb >= 0) ? 1 : 0);
    vectors++;
    if (t != want) begin
      miscompares++;
      $display("[TB] FAIL drain_length: got %0d cycles required %0d", t, want);
    end
    for (int i = 0; i < N; i++) begin
      want = (i == el) ? ROWS - 1 : ROWS;
      vectors++;
      if (cnt[i] != want) begin
        miscompares++;
        $display("[TB] FAIL drain_count lane %0d: got %0d reads required %0d", i, cnt[i], want);
      end
    end
    tick();
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_protocol_idle();
    drain_start = 1'b1;
    drain_en    = 1'b1;
    @(negedge clk);
    vectors++;
    if (rd !== '0) begin
      miscompares++;
      $display("[TB] FAIL idle_drain_rd: rd=%h required 0", rd);
    end
    tick();
    drain_start = 1'b0;
    drain_en    = 1'b0;
    @(negedge clk);
    vectors++;
    if ({err, busy, loaded, rd} !== {1'b1, 1'b0, 1'b0, {N{1'b0}}}) begin
      miscompares++;
      $display("[TB] FAIL idle_drain_err: err=%b busy=%b loaded=%b rd=%h required 1/0/0/0",
               err, busy, loaded, rd);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    test_load(0);
    drain_start = 1'b1;
    drain_en    = 1'b1;
    tick();
    drain_start = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_drain_busy: busy=%b err=%b required 1/1", busy, err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, loaded, done, err, rd} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_drain_reset: busy=%b loaded=%b done=%b err=%b rd=%h required all 0",
               busy, loaded, done, err, rd);
    end
    drain_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load(0);
    test_drain(-1, -1, -1, -1, 1'b0);
    test_reset();
    test_load(3);
    test_drain(2, 7, -1, -1, 1'b0);
    test_reset();
    test_protocol_idle();
    test_reset();
    test_load(0);
    test_drain(-1, -1, 9, 10, 1'b1);
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/weight_fifo_sched.md
Name: weight_fifo_sched

Overview:
- Sequencer for the 16-lane weight FIFO bank of the NN accelerator.
- LOAD phase: takes a serial 8-bit weight stream and distributes it round-robin across the lanes (weight k -> lane k mod N).
- DRAIN phase: issues per-lane read strobes with a systolic skew (lane i starts i cycles after lane 0) so weights enter the PE array diagonally.
- Sits between the ARM-side weight loader and the FIFO bank; owns all rd/wr strobes of the bank.

Parameters:
- N, 16, number of weight FIFO lanes.
- W, 8, weight width in bits.
- ROWS, 16, weights per lane per tile; 1..FIFO depth.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  begin LOAD; honoured only in IDLE.
- in_valid  input  1  in_data holds a valid weight.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  W  weight stream.
- drain_start  input  1  begin DRAIN; honoured only in LOADED.
- drain_en  input  1  PE array advance enable; low stalls DRAIN.
- empty  input  N  per-lane FIFO empty.
- full  input  N  per-lane FIFO full.
- wr  output  N  per-lane FIFO write strobe.
- rd  output  N  per-lane FIFO read strobe.
- data_out  output  W  shared FIFO write data.
- loaded  output  1  high in LOADED state.
- busy  output  1  high in LOAD or DRAIN.
- done  output  1  one-cycle pulse at end of DRAIN.
- err  output  1  sticky underflow/protocol error.

Behaviour:
- Reset: synchronous, active-high, one clock; reset and clk are shared with the FIFO bank.
- Reset values: state=IDLE, lane=0, row=0, skew counter=0; in_ready, wr, rd, loaded, busy, done, err all 0; data_out=0.
- Reset mid-operation: immediate return to IDLE; the bank is cleared by the same reset, so no partial state survives.
- States:
  - IDLE -> LOAD on load_start.
  - LOAD -> LOADED when the (N*ROWS)th weight is accepted.
  - LOADED -> DRAIN on drain_start.
  - DRAIN -> IDLE after the final read; done pulses in the first IDLE cycle.
- LOAD handshake:
  - in_ready = (state==LOAD) && !full[lane].
  - Accept occurs when in_valid && in_ready.
  - wr = onehot(lane) on accept, else 0 (combinational, same cycle as accept).
  - data_out = in_data, combinational pass-through.
- LOAD counters:
  - lane increments on accept, wrapping N-1 -> 0.
  - row increments when lane wraps.
  - Accept at lane=N-1, row=ROWS-1 transitions to LOADED.
- Full lane: in_ready stays low and the stream stalls in place; no skip, no drop.
- in_valid outside LOAD is ignored: wr=0, in_ready=0.
- DRAIN skew counter c:
  - Starts at 0 and advances by 1 each cycle drain_en=1.
  - Holds while drain_en=0; rd=0 during stall cycles.
  - Total span is ROWS+N-1 enabled cycles (c = 0 .. ROWS+N-2).
- DRAIN read strobes:
  - rd[i] = drain_en && (i <= c < i+ROWS).
  - Each lane is read exactly ROWS times.
  - Lane i's first read falls i enabled cycles after lane 0's.
- Underflow: if rd[i] would assert while empty[i]=1, that rd[i] is suppressed, err is set, and the counter still advances.
- Protocol errors: load_start in LOADED/DRAIN, or drain_start in IDLE/LOAD, sets err; the command is otherwise ignored. load_start in LOAD is also ignored, without error.
- err clears only on reset.
- loaded = (state==LOADED).
- busy = (state==LOAD || state==DRAIN).
- Counter widths: lane is clog2(N) bits, row is clog2(ROWS+1) bits, c is clog2(ROWS+N) bits.

Test Plan (N=16, W=8, ROWS=4):
- Reset then idle 5 cycles -> all outputs 0, in_ready=0, state IDLE.
- load_start, then 64 back-to-back valid weights 0..63 -> wr one-hot cycles lanes 0..15 four times; lane 5 receives 5, 21, 37, 53; loaded=1 the cycle after weight 63; in_ready=0 thereafter.
- Same load with full[3]=1 for 3 cycles when lane=3 -> in_ready=0 and wr=0 for those 3 cycles; weight 3 is written to lane 3 once full drops; no data lost.
- drain_start with drain_en=1 -> rd[0] high cycles 0-3, rd[15] high cycles 15-18; done pulses after cycle 18; 19 cycles total; back to IDLE; err=0.
- Drain with drain_en low on cycles 2 and 7 -> rd=0 on those cycles; schedule shifts by 2; done arrives 2 cycles later; still exactly 4 reads per lane.
- drain_start in IDLE -> err=1 and no rd. Separately, during DRAIN force empty[9]=1 at c=10 -> rd[9] suppressed that cycle and err=1. Then reset mid-DRAIN -> next cycle IDLE, rd=0, err=0.
